vn_extend_accumulate: RTL



---
 rtl/vn_extend_accumulate_pkg.sv | 25 ++
 rtl/vn_extend_accumulate_llr_sign_extend.sv | 13 +
 rtl/vn_extend_accumulate.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/vn_extend_accumulate_pkg.sv
// Shared constants, state encoding and counter-width helper for the
// variable-node extend/accumulate front end.
package vn_extend_accumulate_pkg;

    localparam int LLR_WIDTH      = 6;
    localparam int EXTENDED_BITS  = 2;
    localparam int DEGREE_DEFAULT = 3;

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    // Bits needed to index n distinct values, never less than one bit.
    function automatic int cnt_width(input int n);
        int w;
        if (n <= 1) begin
            w = 1;
        end else begin
            w = $clog2(n);
        end
        return w;
    endfunction

endpackage

// File: rtl/vn_extend_accumulate_llr_sign_extend.sv
// Combinational widening of a narrow two's-complement LLR into the
// accumulation domain by replicating its sign bit into the guard bits.
module llr_sign_extend #(
    parameter int WIDTH         = 6,
    parameter int EXTENDED_BITS = 2
) (
    input  logic [WIDTH-1:0]               narrow,
    output logic [WIDTH+EXTENDED_BITS-1:0] wide
);

    assign wide = {{EXTENDED_BITS{narrow[WIDTH-1]}}, narrow};

endmodule

// File: rtl/vn_extend_accumulate.sv
// Variable-node front end: loads one channel LLR plus DEGREE check
// messages, accumulates the posterior total in the extended domain and
// streams DEGREE extrinsic messages (total minus each check message).
module vn_extend_accumulate
    import vn_extend_accumulate_pkg::*;
#(
    parameter int WIDTH         = LLR_WIDTH,
    parameter int EXTENDED_BITS = vn_extend_accumulate_pkg::EXTENDED_BITS,
    parameter int DEGREE        = DEGREE_DEFAULT
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               in_llr,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH+EXTENDED_BITS-1:0] out_msg,
    output logic                           out_last,
    output logic                           out_hard
);

    localparam int OW        = WIDTH + EXTENDED_BITS;
    localparam int IN_CNT_W  = cnt_width(DEGREE + 1);
    localparam int OUT_IDX_W = cnt_width(DEGREE);

    state_t                 state_r;
    state_t                 state_next_s;
    logic [IN_CNT_W-1:0]    in_cnt_r;
    logic [OUT_IDX_W-1:0]   out_idx_r;
    logic [OW-1:0]          total_r;
    logic [OW-1:0]          buf_r [DEGREE];
    logic                   hard_r;

    logic [OW-1:0]          ext_s;
    logic [OW-1:0]          sum_s;
    logic [OW-1:0]          sel_s;
    logic                   in_fire_s;
    logic                   out_fire_s;
    logic                   load_done_s;
    logic                   emit_last_s;

    llr_sign_extend #(
        .WIDTH         (WIDTH),
        .EXTENDED_BITS (EXTENDED_BITS)
    ) u_ext (
        .narrow (in_llr),
        .wide   (ext_s)
    );

    // Handshakes, running sum of the incoming beat and buffer read mux.
    always_comb begin
        in_fire_s   = (state_r == ST_LOAD) && in_valid;
        out_fire_s  = (state_r == ST_EMIT) && out_ready;
        load_done_s = (in_cnt_r == IN_CNT_W'(DEGREE));
        emit_last_s = (out_idx_r == OUT_IDX_W'(DEGREE - 1));
        if (in_cnt_r == {IN_CNT_W{1'b0}}) begin
            sum_s = ext_s;
        end else begin
            sum_s = total_r + ext_s;
        end
        sel_s = {OW{1'b0}};
        for (int k = 0; k < DEGREE; k++) begin
            if (out_idx_r == OUT_IDX_W'(k)) begin
                sel_s = buf_r[k];
            end else begin
                sel_s = sel_s;
            end
        end
    end

    // Next-state and output decode; every output is derived from registers.
    always_comb begin
        state_next_s = state_r;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_msg      = {OW{1'b0}};
        out_last     = 1'b0;
        out_hard     = hard_r;
        case (state_r)
            ST_LOAD: begin
                in_ready = 1'b1;
                if (in_fire_s && load_done_s) begin
                    state_next_s = ST_EMIT;
                end else begin
                    state_next_s = ST_LOAD;
                end
            end
            ST_EMIT: begin
                out_valid = 1'b1;
                out_msg   = total_r - sel_s;
                out_last  = emit_last_s;
                if (out_fire_s && emit_last_s) begin
                    state_next_s = ST_LOAD;
                end else begin
                    state_next_s = ST_EMIT;
                end
            end
            default: begin
                state_next_s = ST_LOAD;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_LOAD;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath: accumulate and buffer on input beats, step the output index.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_cnt_r  <= {IN_CNT_W{1'b0}};
            out_idx_r <= {OUT_IDX_W{1'b0}};
            total_r   <= {OW{1'b0}};
            hard_r    <= 1'b0;
            for (int k = 0; k < DEGREE; k++) begin
                buf_r[k] <= {OW{1'b0}};
            end
        end else begin
            case (state_r)
                ST_LOAD: begin
                    if (in_fire_s) begin
                        total_r <= sum_s;
                        for (int k = 0; k < DEGREE; k++) begin
                            if (in_cnt_r == IN_CNT_W'(k + 1)) begin
                                buf_r[k] <= ext_s;
                            end else begin
                                buf_r[k] <= buf_r[k];
                            end
                        end
                        if (load_done_s) begin
                            // The hard decision is frozen for the whole EMIT phase.
                            in_cnt_r  <= {IN_CNT_W{1'b0}};
                            out_idx_r <= {OUT_IDX_W{1'b0}};
                            hard_r    <= sum_s[OW-1];
                        end else begin
                            in_cnt_r <= in_cnt_r + IN_CNT_W'(1);
                        end
                    end else begin
                        in_cnt_r <= in_cnt_r;
                    end
                end
                ST_EMIT: begin
                    if (out_fire_s) begin
                        if (emit_last_s) begin
                            out_idx_r <= {OUT_IDX_W{1'b0}};
                            in_cnt_r  <= {IN_CNT_W{1'b0}};
                        end else begin
                            out_idx_r <= out_idx_r + OUT_IDX_W'(1);
                        end
                    end else begin
                        out_idx_r <= out_idx_r;
                    end
                end
                default: begin
                    in_cnt_r  <= {IN_CNT_W{1'b0}};
                    out_idx_r <= {OUT_IDX_W{1'b0}};
                end
            endcase
        end
    end

endmodule
